// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_mod.sv
// UART receiver (start + NB_DATA data bits LSB first + stop) clocked by a 16x oversampling tick.
module uart_rx_mod
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done_tick
);

  localparam int S_W = ($clog2(STOP_TICKS) < 4) ? 4 : $clog2(STOP_TICKS);
  localparam int N_W = ($clog2(NB_DATA) < 1) ? 1 : $clog2(NB_DATA);

  localparam logic [S_W-1:0] S_MID       = S_W'(MID_SAMPLE);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(NB_DATA - 1);

  logic rx_s;

  rx_state_e          state_reg, state_next;
  logic [S_W-1:0]     s_reg, s_next;
  logic [N_W-1:0]     n_reg, n_next;
  logic [NB_DATA-1:0] shift_reg, shift_next;
  logic [NB_DATA-1:0] data_reg, data_next;
  logic               done_reg, done_next;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .d       (i_rx),
    .q       (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit so short glitches are rejected.
        if (i_s_tick) begin
          if (s_reg == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            shift_next = {rx_s, shift_reg[NB_DATA-1:1]};
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
            data_next  = shift_reg;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_rx_data      = data_reg;
  assign o_rx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_rx_mod.sv
// Scoreboard bench for uart_rx_mod: default build plus a STOP_TICKS=32 build on its own line.
module tb_uart_rx_mod;

  logic       clk;
  logic       rst_n;
  logic       s_tick;
  logic       rx;
  logic       rx2;
  logic [7:0] data1, data2;
  logic       done1, done2;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;
  int cyc       = 0;
  int last_done1_cyc = 0;
  int done2_cyc      = 0;
  int tick_div       = 0;
  logic       done1_prev = 1'b0;
  logic [7:0] held_exp   = 8'h00;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_rx_mod #(.NB_DATA(8), .STOP_TICKS(16)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_s_tick       (s_tick),
    .i_rx           (rx),
    .o_rx_data      (data1),
    .o_rx_done_tick (done1)
  );

  uart_rx_mod #(.NB_DATA(8), .STOP_TICKS(32)) dut32 (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_s_tick       (s_tick),
    .i_rx           (rx2),
    .o_rx_data      (data2),
    .o_rx_done_tick (done2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 9 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div == 8) ? 0 : tick_div + 1;
      s_tick   = (tick_div == 8);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the default build.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      done1_cnt++;
      last_done1_cyc = cyc;
      if (done1_prev) begin
        check_cnt++;
        $display("FAIL done_width: done high on consecutive clocks");
      end
      if (q1.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_done: got data 0x%0h expected no frame", data1);
      end else begin
        held_exp = q1.pop_front();
        chk("rx_data", int'(data1), int'(held_exp));
        $display("frame rx_data=0x%02h exp=0x%02h t=%0t", data1, held_exp, $time);
      end
    end
    done1_prev = rst_n && done1;
  end

  // Monitor for the STOP_TICKS=32 build.
  always @(negedge clk) begin
    if (rst_n && done2) begin
      done2_cnt++;
      done2_cyc = cyc;
      if (q2.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_done32: got data 0x%0h expected no frame", data2);
      end else begin
        chk("rx_data32", int'(data2), int'(q2.pop_front()));
        $display("frame32 rx_data=0x%02h t=%0t", data2, $time);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int n, input bit both);
    rx  = v;
    rx2 = both ? v : 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_bits(input logic [7:0] b, input int first, input int last, input bit both);
    for (int i = first; i <= last; i++) send_bit(b[i], 16, both);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit both);
    q1.push_back(b);
    if (both) q2.push_back(b);
    send_bit(1'b0, 16, both);
    send_bits(b, 0, 7, both);
    send_bit(1'b1, 16, both);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    rx2   = 1'b1;
    #40;
    chk("reset_data", int'(data1), 0);
    chk("reset_done", int'(done1), 0);
    #15;
    rst_n = 1'b1;
    wait_ticks(4);

    // Frames 0x55 then 0xA3; 0x55 must hold until 0xA3 completes.
    send_frame(8'h55, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    chk("after_55", int'(data1), 8'h55);
    q1.push_back(8'hA3);
    send_bit(1'b0, 16, 1'b0);
    send_bits(8'hA3, 0, 3, 1'b0);
    chk("held_55", int'(data1), 8'h55);
    send_bits(8'hA3, 4, 7, 1'b0);
    send_bit(1'b1, 16, 1'b0);
    send_bit(1'b1, 8, 1'b0);

    // Three-tick low glitch is a false start.
    send_bit(1'b0, 3, 1'b0);
    send_bit(1'b1, 24, 1'b0);
    chk("glitch_data", int'(data1), 8'hA3);
    chk("glitch_no_done", done1_cnt, 2);

    // Reset during data bit 4 of 0xF0, then 0x3C.
    send_bit(1'b0, 16, 1'b0);
    send_bits(8'hF0, 0, 3, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    rst_n = 1'b0;
    rx    = 1'b1;
    held_exp = 8'h00;
    repeat (3) @(negedge clk);
    chk("midreset_data", int'(data1), 0);
    rst_n = 1'b1;
    wait_ticks(4);
    chk("postreset_data", int'(data1), 0);
    chk("postreset_done", int'(done1), 0);
    send_frame(8'h3C, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    chk("after_3c", int'(data1), 8'h3C);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    chk("after_ff", int'(data1), 8'hFF);

    // Same frame to both builds; the 2-stop build finishes 16 ticks (144 clocks) later.
    send_frame(8'h81, 1'b1);
    send_bit(1'b1, 40, 1'b1);
    chk("stop32_delay", done2_cyc - last_done1_cyc, 144);
    chk("data32", int'(data2), 8'h81);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("done1_count", done1_cnt, 6);
    chk("done2_count", done2_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
